sum_display_scan: RTL and testbench

Downstream display stage for the 4-bit adder.
- Accepts the 5-bit adder result (carry plus 4-bit sum) on a valid strobe.
- Converts it to two BCD digits with a sequential shift-add-3 engine.
- Time-multiplexes the two digits onto a common-anode four-digit seven-segment display.
- The adder stays combinational; this block owns all display timing and refresh.

---
 rtl/sum_display_pkg.sv | 42 ++++
 rtl/sum_display_scan_if.sv | 12 +
 rtl/bin2bcd_seq.sv | 75 +++++++
 rtl/sum_display_scan.sv | 73 +++++++
 tb/tb_sum_display_scan.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sum_display_pkg.sv
// Shared types and constants for the adder-result display path:
// conversion FSM states, seven-segment patterns and the digit decoder.
package sum_display_pkg;

  localparam int unsigned SUM_W = 5;
  localparam int unsigned ITER  = 5;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/sum_display_scan_if.sv
// Handshake between the adder and the display stage: result strobe in, busy back.
interface sum_display_scan_if;
  import sum_display_pkg::*;

  logic             sum_valid;
  logic [SUM_W-1:0] sum;
  logic             busy;

  modport master (output sum_valid, output sum, input busy);
  modport slave  (input sum_valid, input sum, output busy);

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to two-digit BCD converter; one bit per cycle,
// done pulses for one cycle in DONE while tens/ones hold the final digits.
module bin2bcd_seq
  import sum_display_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SUM_W-1:0] bin,
  output logic             busy,
  output logic [3:0]       tens,
  output logic [3:0]       ones,
  output logic             done
);

  localparam int unsigned SH_W = 8 + SUM_W;

  state_e            state_q, state_d;
  logic [SH_W-1:0]   sh_q, sh_d, adj;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(ITER - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // Datapath: register is {tens, ones, remaining binary bits}.
  always_comb begin
    adj = sh_q;
    if (adj[SH_W-1 -: 4] >= 4'd5) adj[SH_W-1 -: 4] = adj[SH_W-1 -: 4] + 4'd3;
    if (adj[SH_W-5 -: 4] >= 4'd5) adj[SH_W-5 -: 4] = adj[SH_W-5 -: 4] + 4'd3;
    sh_d  = sh_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        sh_d  = {8'd0, bin};
        cnt_d = '0;
      end
      SHIFT: begin
        sh_d  = {adj[SH_W-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  assign tens = sh_q[SH_W-1 -: 4];
  assign ones = sh_q[SH_W-5 -: 4];

endmodule

// File: rtl/sum_display_scan.sv
// Display stage for the 4-bit adder: BCD conversion, digit registers and a
// two-digit multiplexed scan. Define SUM_DISPLAY_BLANK_LEADING_EN to blank a zero tens digit.
module sum_display_scan
  import sum_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  sum_display_scan_if.slave   bus,
  output logic [6:0]          seg,
  output logic [3:0]          an,
  output logic                dp
);

  localparam int unsigned SCAN_W = $clog2(REFRESH_DIV);

  logic              busy, done;
  logic [3:0]        conv_tens, conv_ones;
  logic [3:0]        disp_tens_q, disp_ones_q;
  logic [SCAN_W-1:0] scan_cnt_q;
  logic              idx_q, wrap;
  logic [3:0]        digit;

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (bus.sum_valid),
    .bin   (bus.sum),
    .busy  (busy),
    .tens  (conv_tens),
    .ones  (conv_ones),
    .done  (done)
  );

  assign bus.busy = busy;

  // Both digits commit on the same edge so a half-updated value is never shown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_tens_q <= '0;
      disp_ones_q <= '0;
    end else if (done) begin
      disp_tens_q <= conv_tens;
      disp_ones_q <= conv_ones;
    end
  end

  assign wrap = (scan_cnt_q == SCAN_W'(REFRESH_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      idx_q      <= 1'b0;
    end else if (wrap) begin
      scan_cnt_q <= '0;
      idx_q      <= ~idx_q;
    end else begin
      scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
    end
  end

  always_comb begin
    digit = idx_q ? disp_tens_q : disp_ones_q;
    an    = idx_q ? 4'b1101 : 4'b1110;
    dp    = 1'b1;
    seg   = seg_decode(digit);
`ifdef SUM_DISPLAY_BLANK_LEADING_EN
    if (idx_q && (disp_tens_q == 4'd0)) seg = SEG_BLANK;
`endif
  end

endmodule

// File: tb/tb_sum_display_scan.sv
// Randomised self-checking bench for sum_display_scan with a decimal reference model.
module tb_sum_display_scan;

  localparam int unsigned DIV = 4;
  localparam int BUSY_CYCLES = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  int         checks = 0;
  int         errors = 0;

  sum_display_scan_if bus ();

  sum_display_scan #(.REFRESH_DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .seg   (seg),
    .an    (an),
    .dp    (dp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] digit_seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] tens_seg(input int t);
`ifdef SUM_DISPLAY_BLANK_LEADING_EN
    if (t == 0) return 7'b1111111;
`endif
    return digit_seg(t);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe one value and count how many post-edge samples show busy.
  task automatic convert(input int value, output int busy_n, output bit timeout);
    bus.sum_valid = 1'b1;
    bus.sum = 5'(value);
    tick();
    bus.sum_valid = 1'b0;
    busy_n = 0;
    timeout = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!bus.busy) begin
        timeout = 1'b0;
        break;
      end
      busy_n++;
      tick();
    end
  endtask

  task automatic wait_idle(output bit timeout);
    timeout = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!bus.busy) begin
        timeout = 1'b0;
        break;
      end
      tick();
    end
  endtask

  // Watch one full scan period and capture what each lit digit shows.
  task automatic observe(output logic [6:0] s_ones, output logic [6:0] s_tens, output bit ok);
    bit seen_o = 1'b0, seen_t = 1'b0;
    s_ones = 'x;
    s_tens = 'x;
    for (int i = 0; i < 2 * DIV + 1; i++) begin
      tick();
      if (an == 4'b1110) begin
        s_ones = seg;
        seen_o = 1'b1;
      end else if (an == 4'b1101) begin
        s_tens = seg;
        seen_t = 1'b1;
      end
    end
    ok = seen_o && seen_t;
  endtask

  task automatic verify_value(input string name, input int value);
    logic [6:0] so, st;
    bit ok;
    observe(so, st, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s scan: both digits not lit within %0d cycles", name, 2 * DIV + 1);
    end
    checks++;
    if (so !== digit_seg(value % 10)) begin
      errors++;
      $display("FAIL %s ones: seg=%b expected %b", name, so, digit_seg(value % 10));
    end
    checks++;
    if (st !== tens_seg(value / 10)) begin
      errors++;
      $display("FAIL %s tens: seg=%b expected %b", name, st, tens_seg(value / 10));
    end
  endtask

  task automatic test_reset();
    bus.sum_valid = 1'b0;
    bus.sum = '0;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({an, seg, bus.busy, dp} !== {4'b1110, 7'b1000000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset: an=%b seg=%b busy=%b dp=%b expected 1110 1000000 0 1",
               an, seg, bus.busy, dp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    verify_value("reset_display", 0);
  endtask

  task automatic test_scan();
    logic [3:0] prev;
    int run = 0;
    bit first = 1'b1;
    bit bad_an = 1'b0, bad_run = 1'b0;
    tick();
    prev = an;
    for (int i = 0; i < 6 * DIV; i++) begin
      tick();
      run++;
      if (an[3:2] !== 2'b11 || (an !== 4'b1110 && an !== 4'b1101)) bad_an = 1'b1;
      if (an !== prev) begin
        if (!first && run != DIV) bad_run = 1'b1;
        first = 1'b0;
        run = 0;
        prev = an;
      end
    end
    checks++;
    if (bad_an) begin
      errors++;
      $display("FAIL scan_an: illegal anode pattern seen, last an=%b", an);
    end
    checks++;
    if (bad_run || first) begin
      errors++;
      $display("FAIL scan_period: digit dwell not %0d cycles (last run %0d)", DIV, run);
    end
  endtask

  task automatic test_max();
    int n;
    bit to;
    convert(30, n, to);
    checks++;
    if (to || n != BUSY_CYCLES) begin
      errors++;
      $display("FAIL max_busy: busy cycles=%0d timeout=%0b expected %0d", n, to, BUSY_CYCLES);
    end
    verify_value("max30", 30);
  endtask

  task automatic test_single_digit();
    int n;
    bit to;
    convert(9, n, to);
    verify_value("sum9", 9);
    convert(16, n, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL sum16_busy: busy never dropped");
    end
    verify_value("sum16", 16);
  endtask

  task automatic test_dropped();
    bit to;
    bus.sum_valid = 1'b1;
    bus.sum = 5'd15;
    tick();
    bus.sum_valid = 1'b0;
    tick();
    bus.sum_valid = 1'b1;
    bus.sum = 5'd3;
    tick();
    bus.sum_valid = 1'b0;
    wait_idle(to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL dropped_busy: busy never dropped");
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL dropped_queue: busy=%b expected 0 (strobe queued)", bus.busy);
    end
    verify_value("dropped", 15);
  endtask

  task automatic test_back_to_back();
    bit to;
    // Strobe landing on the commit edge is ignored.
    bus.sum_valid = 1'b1;
    bus.sum = 5'd11;
    tick();
    bus.sum_valid = 1'b0;
    repeat (5) tick();
    bus.sum_valid = 1'b1;
    bus.sum = 5'd20;
    tick();
    bus.sum_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL edge6_strobe: busy=%b expected 0", bus.busy);
    end
    verify_value("edge6", 11);
    // Strobe on the first edge after commit is accepted.
    bus.sum_valid = 1'b1;
    bus.sum = 5'd7;
    tick();
    bus.sum_valid = 1'b0;
    repeat (6) tick();
    bus.sum_valid = 1'b1;
    bus.sum = 5'd28;
    tick();
    bus.sum_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL edge7_accept: busy=%b expected 1", bus.busy);
    end
    wait_idle(to);
    verify_value("edge7", 28);
  endtask

  task automatic test_random();
    int n, v;
    bit to;
    for (int i = 0; i < 10; i++) begin
      v = int'($urandom_range(30, 0));
      convert(v, n, to);
      checks++;
      if (to || n != BUSY_CYCLES) begin
        errors++;
        $display("FAIL rand_busy: sum=%0d busy cycles=%0d expected %0d", v, n, BUSY_CYCLES);
      end
      verify_value($sformatf("rand%0d", v), v);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit to;
    convert(5, n, to);
    verify_value("pre05", 5);
    bus.sum_valid = 1'b1;
    bus.sum = 5'd22;
    tick();
    bus.sum_valid = 1'b0;
    tick();
    tick();
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({an, seg, bus.busy, dp} !== {4'b1110, 7'b1000000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL mid_reset: an=%b seg=%b busy=%b dp=%b expected 1110 1000000 0 1",
               an, seg, bus.busy, dp);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_busy: busy=%b expected 0", bus.busy);
    end
    verify_value("after_abort", 0);
    convert(22, n, to);
    checks++;
    if (to || n != BUSY_CYCLES) begin
      errors++;
      $display("FAIL reconv_busy: busy cycles=%0d expected %0d", n, BUSY_CYCLES);
    end
    verify_value("reconv22", 22);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_max();
    test_single_digit();
    test_dropped();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
